// File: rtl/jtkcpu_shseq.sv
// Repeats one single-step ALU shift/rotate op `cnt` times, feeding result and flags back each cen cycle.
// Latency cnt+1 cen cycles from start to done; start is ignored unless idle, cen=0 freezes everything.
module jtkcpu_shseq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        start,
  input  logic [7:0]  op_in,
  input  logic [7:0]  cnt,
  input  logic [15:0] din,
  input  logic [7:0]  cc_in,
  output logic [7:0]  alu_op,
  output logic [15:0] alu_opnd0,
  output logic [7:0]  alu_cc,
  input  logic [15:0] alu_rslt,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_h,
  output logic        busy,
  output logic        done,
  output logic [15:0] dout,
  output logic [7:0]  cc_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  op_r_q;
  logic [15:0] acc_q;
  logic [7:0]  cc_r_q;
  logic [7:0]  rem_q;
  logic [7:0]  cc_d;

  // ALU flags overwrite C,V,Z,N,H; bits 4, 6 and 7 ride through untouched.
  always_comb begin
    cc_d    = cc_r_q;
    cc_d[0] = alu_c;
    cc_d[1] = alu_v;
    cc_d[2] = alu_z;
    cc_d[3] = alu_n;
    cc_d[5] = alu_h;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_r_q  <= 8'h00;
      acc_q   <= 16'h0000;
      cc_r_q  <= 8'h00;
      rem_q   <= 8'h00;
    end else if (cen) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_r_q  <= op_in;
            acc_q   <= din;
            cc_r_q  <= cc_in;
            rem_q   <= cnt;
            state_q <= (cnt == 8'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          acc_q  <= alu_rslt;
          cc_r_q <= cc_d;
          rem_q  <= rem_q - 8'd1;
          if (rem_q == 8'd1) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_op    = op_r_q;
  assign alu_opnd0 = acc_q;
  assign alu_cc    = cc_r_q;

  // acc/cc_r only move in RUN or on an accepted start, so they already hold the result until then.
  assign dout   = acc_q;
  assign cc_out = cc_r_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_jtkcpu_shseq.sv
// Bench for jtkcpu_shseq: behavioural ALU on the loop, arithmetic reference for final operand/flags.
module tb_jtkcpu_shseq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic        start;
  logic [7:0]  op_in;
  logic [7:0]  cnt;
  logic [15:0] din;
  logic [7:0]  cc_in;
  logic [7:0]  alu_op;
  logic [15:0] alu_opnd0;
  logic [7:0]  alu_cc;
  logic [15:0] alu_rslt;
  logic        alu_c, alu_v, alu_z, alu_n, alu_h;
  logic        busy, done;
  logic [15:0] dout;
  logic [7:0]  cc_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtkcpu_shseq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .start     (start),
    .op_in     (op_in),
    .cnt       (cnt),
    .din       (din),
    .cc_in     (cc_in),
    .alu_op    (alu_op),
    .alu_opnd0 (alu_opnd0),
    .alu_cc    (alu_cc),
    .alu_rslt  (alu_rslt),
    .alu_c     (alu_c),
    .alu_v     (alu_v),
    .alu_z     (alu_z),
    .alu_n     (alu_n),
    .alu_h     (alu_h),
    .busy      (busy),
    .done      (done),
    .dout      (dout),
    .cc_out    (cc_out)
  );

  // Single-step ALU stand-in: {rslt, c, v, z, n, h}
  function automatic logic [20:0] alu_step(input logic [7:0] op, input logic [15:0] a,
                                           input logic [7:0] cc);
    logic [15:0] r;
    logic        c, v;
    r = a; c = cc[0]; v = cc[1];
    case (op)
      8'hB8: begin r = {1'b0, a[15:1]};  c = a[0]; end
      8'hBE: begin r = {a[14:0], 1'b0};  c = a[15]; v = a[15] ^ a[14]; end
      8'hBA: begin r = {cc[0], a[15:1]}; c = a[0]; end
      8'hC0: begin r = {a[14:0], cc[0]}; c = a[15]; v = a[15] ^ a[14]; end
      8'hBC: begin r = {a[15], a[15:1]}; c = a[0]; end
      default: ;
    endcase
    return {r, c, v, (r == 16'h0000), r[15], cc[5]};
  endfunction

  always_comb {alu_rslt, alu_c, alu_v, alu_z, alu_n, alu_h} = alu_step(alu_op, alu_opnd0, alu_cc);

  // Reference: repeat the instruction n times on plain integers, return {dout, cc_out}
  function automatic logic [23:0] ref_run(input logic [7:0] op, input logic [15:0] d,
                                          input logic [7:0] n, input logic [7:0] cc);
    logic [31:0] x, nc;
    logic [7:0]  f;
    x = {16'h0, d};
    f = cc;
    for (int i = 0; i < int'(n); i++) begin
      case (op)
        8'hB8: begin f[0] = x[0]; x = x / 2; end
        8'hBE: begin
          f[0] = (x >= 32768);
          f[1] = ((x >= 32768) != ((x / 16384) % 2 == 1));
          x = (x * 2) % 65536;
        end
        8'hBA: begin nc = x % 2; x = x / 2 + (f[0] ? 32768 : 0); f[0] = nc[0]; end
        8'hC0: begin
          nc = (x >= 32768) ? 1 : 0;
          f[1] = ((x >= 32768) != ((x / 16384) % 2 == 1));
          x = (x * 2) % 65536 + (f[0] ? 1 : 0);
          f[0] = nc[0];
        end
        8'hBC: begin nc = (x >= 32768) ? 32768 : 0; f[0] = x[0]; x = x / 2 + nc; end
        default: ;
      endcase
      f[2] = (x == 0);
      f[3] = (x >= 32768);
    end
    return {x[15:0], f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, expv);
    end
  endtask

  // One full transaction; tog alternates cen, spam throws extra start pulses while busy.
  task automatic run_seq(input string tag, input logic [7:0] op, input logic [15:0] d,
                         input logic [7:0] n, input logic [7:0] c, input bit tog, input bit spam);
    logic [23:0] expv;
    int          edges, guard;
    bit          cur;
    expv = ref_run(op, d, n, c);
    @(negedge clk);
    chk({tag, "/idle"}, {31'd0, busy}, 32'd0);
    cen = 1'b1; start = 1'b1; op_in = op; din = d; cnt = n; cc_in = c;
    @(negedge clk);
    start = 1'b0;
    op_in = 8'($urandom); din = 16'($urandom); cnt = 8'($urandom); cc_in = 8'($urandom);
    chk({tag, "/busy"}, {31'd0, busy}, 32'd1);
    edges = 0; guard = 0; cur = 1'b1;
    while (!done && guard < 2000) begin
      cur   = tog ? !cur : 1'b1;
      cen   = cur;
      start = spam ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      if (cur) edges++;
      guard++;
    end
    start = 1'b0;
    chk({tag, "/timeout"}, {31'd0, (guard < 2000)}, 32'd1);
    chk({tag, "/latency"}, edges, {24'd0, n});
    chk({tag, "/dout"}, {16'd0, dout}, {16'd0, expv[23:8]});
    chk({tag, "/cc"}, {24'd0, cc_out}, {24'd0, expv[7:0]});
    if (tog) begin
      cen = 1'b0;
      @(negedge clk);
      chk({tag, "/done_frozen"}, {31'd0, done}, 32'd1);
    end
    cen = 1'b1;
    @(negedge clk);
    chk({tag, "/done_pulse"}, {30'd0, done, busy}, 32'd0);
    chk({tag, "/dout_hold"}, {16'd0, dout}, {16'd0, expv[23:8]});
  endtask

  initial begin
    logic [7:0] ops [6];
    bit         seen;
    ops = '{8'hB8, 8'hBE, 8'hBA, 8'hC0, 8'hBC, 8'h00};
    rst_n = 1'b0; cen = 1'b0; start = 1'b0;
    op_in = 8'h00; cnt = 8'h00; din = 16'h0000; cc_in = 8'h00;
    #1;
    chk("rst/outs", {busy, done, dout, cc_out, 6'd0}, 32'd0);
    chk("rst/alu", {alu_op, alu_opnd0, alu_cc}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_seq("lsrd3", 8'hB8, 16'h8000, 8'd3, 8'h00, 1'b0, 1'b0);
    chk("lsrd3/const", {16'd0, dout}, 32'h1000);
    chk("lsrd3/flags", {29'd0, cc_out[3], cc_out[2], cc_out[0]}, 32'd0);

    run_seq("asld16", 8'hBE, 16'h0001, 8'd16, 8'h00, 1'b0, 1'b0);
    chk("asld16/const", {16'd0, dout}, 32'h0000);
    chk("asld16/zc", {30'd0, cc_out[2], cc_out[0]}, 32'd3);

    run_seq("rord1", 8'hBA, 16'h0000, 8'd1, 8'h01, 1'b0, 1'b0);
    chk("rord1/const", {16'd0, dout}, 32'h8000);
    chk("rord1/nzc", {29'd0, cc_out[3], cc_out[2], cc_out[0]}, 32'd4);

    run_seq("cnt0", 8'hB8, 16'h1234, 8'd0, 8'hA5, 1'b0, 1'b0);
    chk("cnt0/const", {8'd0, dout, cc_out}, 32'h1234A5);

    run_seq("asrd4", 8'hBC, 16'h8000, 8'd4, 8'h00, 1'b1, 1'b1);
    chk("asrd4/const", {16'd0, dout}, 32'hF800);

    run_seq("asld20", 8'hBE, 16'($urandom) | 16'h0001, 8'd20, 8'($urandom), 1'b0, 1'b0);
    chk("asld20/const", {16'd0, dout}, 32'h0000);

    // Reset mid-RUN of an 8-step LSRD
    @(negedge clk);
    cen = 1'b1; start = 1'b1; op_in = 8'hB8; din = 16'hFFFF; cnt = 8'd8; cc_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst/outs", {busy, done, dout, cc_out, 6'd0}, 32'd0);
    chk("midrst/alu", {alu_op, alu_opnd0, alu_cc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst/no_done", {31'd0, seen}, 32'd0);
    run_seq("postrst", 8'hB8, 16'hFFFF, 8'd8, 8'hFF, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] op, n;
      op = ops[$urandom_range(5)];
      if (op == 8'h00) op = 8'($urandom);
      n = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(40));
      run_seq($sformatf("rnd%0d", i), op, 16'($urandom), n, 8'($urandom),
              1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
